stage2_maxpool: RTL and testbench
=================================

Name: stage2_maxpool

Overview:
- Streaming 2x2, stride-2 max-pool placed directly downstream of the stage-2 convolution core.
- Consumes one post-ReLU pixel per valid beat for all CH channels in parallel, in raster order, from an IN_X x IN_Y feature map.
- Emits an (IN_X/2) x (IN_Y/2) pooled map, one output beat per 2x2 window, to the stage-3 / flatten logic.
- Uses a half-row buffer and does not stall; no back-pressure.

Parameters:
- CH, 3, number of channels processed in parallel.
- DW, 32, bits per channel sample. Input is unsigned; post-ReLU values are never negative.
- IN_X, 8, input columns. Must be even and ≥ 2.
- IN_Y, 8, input rows. Must be even and ≥ 2.

Ports:
- clk  input  1  clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_in_valid  input  1  input beat qualifier; may be deasserted between any two beats.
- i_in_fmap  input  CH*DW  one pixel; channel c occupies bits [c*DW +: DW].
- o_ot_valid  output  1  one-cycle pulse per pooled result.
- o_ot_fmap  output  CH*DW  pooled pixel, same channel packing as the input.

Behaviour:
- Reset (reset=1 at a clock edge):
  - col, row, pair registers, half-row buffer, o_ot_valid and o_ot_fmap all go to 0.
  - Reset has priority over i_in_valid.
  - Reset in the middle of a frame discards the partial frame. The next valid beat is treated as pixel (row 0, col 0).
- Counters:
  - col runs 0..IN_X-1 and row runs 0..IN_Y-1. Both advance only on a valid beat.
  - At col=IN_X-1, col wraps to 0 and row increments.
  - At (IN_Y-1, IN_X-1), both wrap to 0. The next frame may follow on the very next cycle with no gap.
- Per channel c, on a valid beat:
  - Even col: pair[c] <= pixel.
  - Odd col: h = max(pair[c], pixel), an unsigned compare. If both are equal, either may be taken (the values are identical).
  - Even row, odd col: buf[c][col>>1] <= h. No output.
  - Odd row, odd col: o_ot_fmap[c] <= max(h, buf[c][col>>1]) and o_ot_valid <= 1.
  - Half-row buffer depth is IN_X/2 entries per channel.
- Output timing:
  - o_ot_valid is high for exactly the one cycle after the accepting edge of the bottom-right pixel of each window. Latency is 1 cycle.
  - In all other cycles o_ot_valid = 0 and o_ot_fmap holds its last value.
- Ordering and count:
  - Output beats leave in raster order of the pooled map.
  - Exactly (IN_X/2)*(IN_Y/2) beats per frame: 16 at the defaults.
- Gaps: idle cycles (i_in_valid=0) anywhere, including between the two pixels of a pair, leave all state unchanged and produce no output.
- Width: no truncation, no saturation, no sign handling; the output is bit-exact to the chosen input.

Optional Feature:
- Macro: STAGE2_MAXPOOL_LAST_EN.
- Defined:
  - Adds output port o_ot_last (1 bit, reset 0).
  - o_ot_last is asserted together with o_ot_valid on the final pooled beat of a frame, i.e. pooled position (IN_Y/2-1, IN_X/2-1). It is 0 at all other times.
  - Adds a pooled-beat counter that resets to 0 on reset and on frame wrap.
- Not defined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Ramp input, channel c pixel = 100*c + row*8 + col, continuous valid, defaults. Require:
  - 16 o_ot_valid pulses.
  - Beat k (pr=k/4, pc=k%4) carries ch c = 100*c + (2pr+1)*8 + 2pc+1.
  - First pulse arrives the cycle after input pixel (1,1), i.e. valid-beat index 9.
- Max in the top-left of the window: set pixel (0,0)=0xFFFF_FFF0 on ch0, all others 5. Require pooled (0,0) ch0 = 0xFFFF_FFF0 and all other outputs 5. This checks the unsigned compare and buffer retention.
- Random gaps: toggle i_in_valid with 50% random idle cycles. Require outputs identical in value and order to the gap-free run, and each o_ot_valid pulse exactly 1 cycle after the accepting edge of its window's bottom-right pixel.
- Back-to-back frames: two ramp frames with no gap; the second is offset by +1000. Require 32 pulses, the second 16 to be the first 16 values + 1000, and no cross-frame mixing.
- Mid-frame reset: assert reset for 1 cycle after 21 valid beats (row 2, col 5 pending), then send a full frame of constant 7. Require:
  - o_ot_valid=0 and o_ot_fmap=0 the cycle after reset.
  - Then exactly 16 outputs, all 7.
- With STAGE2_MAXPOOL_LAST_EN: in the ramp test, require o_ot_last=1 only on beat 15 (value ch0=63), and 0 after reset.

Source files
------------

// File: rtl/stage2_maxpool_if.sv
// Valid-qualified pixel stream between the conv core, the max-pool and the flatten stage.
// With STAGE2_MAXPOOL_LAST_EN defined the stream also carries an end-of-frame marker.
interface stage2_maxpool_if #(
    parameter int W = 96
);
    logic         valid;
    logic [W-1:0] fmap;
`ifdef STAGE2_MAXPOOL_LAST_EN
    logic         last;

    modport master (output valid, fmap, last);
    modport slave  (input  valid, fmap, last);
`else
    modport master (output valid, fmap);
    modport slave  (input  valid, fmap);
`endif
endinterface

// File: rtl/stage2_maxpool.sv
// Streaming 2x2 stride-2 max-pool over a raster-ordered CH-channel feature map.
// Optional STAGE2_MAXPOOL_LAST_EN adds o_ot_last on the final pooled beat of a frame.
module stage2_maxpool #(
    parameter int CH   = 3,
    parameter int DW   = 32,
    parameter int IN_X = 8,
    parameter int IN_Y = 8
) (
    input  logic             clk,
    input  logic             reset,
    stage2_maxpool_if.slave  in_bus,
    stage2_maxpool_if.master ot_bus
);
    localparam int HX = IN_X / 2;
    localparam int XW = (IN_X > 2) ? $clog2(IN_X) : 1;
    localparam int YW = (IN_Y > 2) ? $clog2(IN_Y) : 1;
    localparam int BW = (HX > 1) ? $clog2(HX) : 1;

    logic [XW-1:0]      col_q, col_d;
    logic [YW-1:0]      row_q, row_d;
    logic [DW-1:0]      pair_q [CH];
    logic [DW-1:0]      pair_d [CH];
    logic [DW-1:0]      buf_q  [CH][HX];
    logic [DW-1:0]      buf_d  [CH][HX];
    logic               ot_valid_q, ot_valid_d;
    logic [CH*DW-1:0]   ot_fmap_q, ot_fmap_d;

    logic [DW-1:0]      pix_w  [CH];
    logic [DW-1:0]      hmax_w [CH];
    logic [BW-1:0]      half_idx;
    logic               emit;

    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign pix_w[g]  = in_bus.fmap[g*DW +: DW];
        assign hmax_w[g] = umax(pair_q[g], pix_w[g]);
    end

    assign half_idx = BW'(col_q >> 1);
    assign emit     = in_bus.valid & col_q[0] & row_q[0];

    // Even rows park the horizontal max per pair; odd rows combine it with the parked value.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        pair_d     = pair_q;
        buf_d      = buf_q;
        ot_valid_d = emit;
        ot_fmap_d  = ot_fmap_q;
        if (in_bus.valid) begin
            if (col_q == XW'(IN_X - 1)) begin
                col_d = '0;
                row_d = (row_q == YW'(IN_Y - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int c = 0; c < CH; c++) begin
                if (!col_q[0]) begin
                    pair_d[c] = pix_w[c];
                end else if (!row_q[0]) begin
                    buf_d[c][half_idx] = hmax_w[c];
                end else begin
                    ot_fmap_d[c*DW +: DW] = umax(hmax_w[c], buf_q[c][half_idx]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            ot_valid_q <= 1'b0;
            ot_fmap_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                pair_q[c] <= '0;
                for (int i = 0; i < HX; i++) begin
                    buf_q[c][i] <= '0;
                end
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            pair_q     <= pair_d;
            buf_q      <= buf_d;
            ot_valid_q <= ot_valid_d;
            ot_fmap_q  <= ot_fmap_d;
        end
    end

    assign ot_bus.valid = ot_valid_q;
    assign ot_bus.fmap  = ot_fmap_q;

`ifdef STAGE2_MAXPOOL_LAST_EN
    localparam int NP = (IN_X / 2) * (IN_Y / 2);
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    logic [PW-1:0] pool_cnt_q, pool_cnt_d;
    logic          ot_last_q, ot_last_d;

    // The pooled-beat counter wraps exactly when the frame's last window is emitted.
    always_comb begin
        pool_cnt_d = pool_cnt_q;
        ot_last_d  = 1'b0;
        if (emit) begin
            if (pool_cnt_q == PW'(NP - 1)) begin
                pool_cnt_d = '0;
                ot_last_d  = 1'b1;
            end else begin
                pool_cnt_d = pool_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pool_cnt_q <= '0;
            ot_last_q  <= 1'b0;
        end else begin
            pool_cnt_q <= pool_cnt_d;
            ot_last_q  <= ot_last_d;
        end
    end

    assign ot_bus.last = ot_last_q;
`endif
endmodule

// File: tb/tb_stage2_maxpool.sv
// Directed bench for stage2_maxpool: ramp, top-left max, random gaps, back-to-back frames, mid-frame reset.
module tb_stage2_maxpool;
    localparam int CH   = 3;
    localparam int DW   = 32;
    localparam int IN_X = 8;
    localparam int IN_Y = 8;
    localparam int W    = CH * DW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stage2_maxpool_if #(.W(W)) inBus ();
    stage2_maxpool_if #(.W(W)) otBus ();

    stage2_maxpool #(
        .CH   (CH),
        .DW   (DW),
        .IN_X (IN_X),
        .IN_Y (IN_Y)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_bus (inBus),
        .ot_bus (otBus)
    );

    int checks     = 0;
    int failures   = 0;
    int pulses     = 0;
    int firstPulse = -1;
    logic [W-1:0] expFmap = '0;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] pixelOf(input int mode, input int offset, input int ch, input int r, input int c);
        case (mode)
            0:       return DW'(offset + 100 * ch + r * 8 + c);
            1:       return (ch == 0 && r == 0 && c == 0) ? 32'hFFFF_FFF0 : 32'd5;
            default: return 32'd7;
        endcase
    endfunction

    function automatic logic [DW-1:0] expOf(input int mode, input int offset, input int ch, input int pr, input int pc);
        case (mode)
            0:       return DW'(offset + 100 * ch + (2 * pr + 1) * 8 + 2 * pc + 1);
            1:       return (ch == 0 && pr == 0 && pc == 0) ? 32'hFFFF_FFF0 : 32'd5;
            default: return 32'd7;
        endcase
    endfunction

    task automatic applyStimulus(input logic v, input logic [W-1:0] pix, input logic expV,
                                 input logic [W-1:0] expF, input logic expL, input string tag);
        inBus.valid = v;
        inBus.fmap  = pix;
        @(posedge clk);
        #1;
        checkOutput({tag, " valid"}, W'(otBus.valid), W'(expV));
        checkOutput({tag, " fmap"}, otBus.fmap, expF);
`ifdef STAGE2_MAXPOOL_LAST_EN
        checkOutput({tag, " last"}, W'(otBus.last), W'(expL));
`else
        if (expL && !expV) $display("[TB] note: last expected without valid in %s", tag);
`endif
        if (otBus.valid) pulses++;
    endtask

    task automatic runPattern(input int mode, input int offset, input int gaps, input int maxBeats, input string tag);
        int n = 0;
        for (int r = 0; r < IN_Y; r++) begin
            for (int c = 0; c < IN_X; c++) begin
                logic [W-1:0] pix;
                logic         odd;
                logic         isLast;
                if (n >= maxBeats) return;
                while (gaps != 0 && $urandom_range(0, 1) == 1) begin
                    applyStimulus(1'b0, {$urandom, $urandom, $urandom}, 1'b0, expFmap, 1'b0, {tag, " idle"});
                end
                for (int ch = 0; ch < CH; ch++) pix[ch*DW +: DW] = pixelOf(mode, offset, ch, r, c);
                odd    = (r % 2 == 1) && (c % 2 == 1);
                isLast = (r == IN_Y - 1) && (c == IN_X - 1);
                if (odd) begin
                    for (int ch = 0; ch < CH; ch++) expFmap[ch*DW +: DW] = expOf(mode, offset, ch, r / 2, c / 2);
                    if (firstPulse < 0) firstPulse = n;
                end
                applyStimulus(1'b1, pix, odd, expFmap, isLast, {tag, " beat"});
                n++;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        inBus.valid = 1'b0;
        inBus.fmap  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid", W'(otBus.valid), W'(1'b0));
        checkOutput("reset fmap", otBus.fmap, '0);
`ifdef STAGE2_MAXPOOL_LAST_EN
        checkOutput("reset last", W'(otBus.last), W'(1'b0));
`endif
        reset = 1'b0;

        $display("[TB] ramp frame");
        pulses = 0; firstPulse = -1;
        runPattern(0, 0, 0, 64, "ramp");
        checkOutput("ramp pulse count", W'(pulses), W'(16));
        checkOutput("ramp first pulse beat", W'(firstPulse), W'(9));

        $display("[TB] top-left max frame");
        pulses = 0;
        runPattern(1, 0, 0, 64, "topleft");
        checkOutput("topleft pulse count", W'(pulses), W'(16));

        $display("[TB] ramp with random gaps");
        pulses = 0;
        runPattern(0, 0, 1, 64, "gaps");
        checkOutput("gaps pulse count", W'(pulses), W'(16));

        $display("[TB] back-to-back frames");
        pulses = 0;
        runPattern(0, 0, 0, 64, "b2b0");
        runPattern(0, 1000, 0, 64, "b2b1");
        checkOutput("b2b pulse count", W'(pulses), W'(32));

        $display("[TB] mid-frame reset");
        runPattern(0, 0, 0, 21, "partial");
        reset       = 1'b1;
        inBus.valid = 1'b1;
        inBus.fmap  = {3{32'h0000_0009}};
        @(posedge clk);
        #1;
        checkOutput("post-reset valid", W'(otBus.valid), W'(1'b0));
        checkOutput("post-reset fmap", otBus.fmap, '0);
`ifdef STAGE2_MAXPOOL_LAST_EN
        checkOutput("post-reset last", W'(otBus.last), W'(1'b0));
`endif
        reset   = 1'b0;
        expFmap = '0;
        pulses  = 0;
        runPattern(2, 0, 0, 64, "const7");
        checkOutput("const7 pulse count", W'(pulses), W'(16));

        applyStimulus(1'b0, '0, 1'b0, expFmap, 1'b0, "tail idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
